// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temp-register stepping controller and the lab control FSM.
package temp_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, STEP, WAIT, DONE} state_t;

    localparam int SETTLE_CYCLES = 2;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_t;

    // {negative, positive, zero} is only trustworthy when exactly one bit is set
    function automatic logic flags_onehot(input logic [2:0] f);
        return (f != 3'b000) && ((f & (f - 3'b001)) == 3'b000);
    endfunction
endpackage

// File: rtl/temp_step_controller_if.sv
// Command/flag bus between the stepping controller (master) and the temp status register (slave).
interface temp_step_controller_if #(parameter int DATA_W = 8);
    logic              load;
    logic              increment;
    logic              decrement;
    logic [DATA_W-1:0] data;
    logic              negative;
    logic              positive;
    logic              zero;

    modport master (output load, increment, decrement, data,
                    input  negative, positive, zero);
    modport slave  (input  load, increment, decrement, data,
                    output negative, positive, zero);
endinterface

// File: rtl/temp_step_controller_step_prescaler.sv
// Step-period counter 0..DIV-1; period_elapsed fires LEAD cycles before the period closes.
module step_prescaler #(
    parameter int DIV  = 4,
    parameter int LEAD = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic period_elapsed
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1 - LEAD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     cnt <= '0;
        else if (clr || cnt == LAST)   cnt <= '0;
        else                           cnt <= cnt + CW'(1);
    end

    // LEAD lets the owner spend its own decision cycles inside the period
    assign period_elapsed = (cnt == TERM);
endmodule

// File: rtl/temp_step_controller.sv
// Loads the temp register, then steps it toward zero using only its flags as feedback.
// Optional abort input enabled by defining TEMP_CTRL_ABORT_EN.
module temp_step_controller
    import temp_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STEP_DIV  = 4,
    parameter int MAX_STEPS = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_W-1:0]      init_value,
`ifdef TEMP_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    temp_step_controller_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      step_count,
    output logic                   fault,
    output logic                   timeout
);
    localparam logic [DATA_W-1:0] MAX_CNT = DATA_W'(MAX_STEPS);

    state_t              state, nstate;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                load_q, inc_q, dec_q;
    logic [DATA_W-1:0]   data_q;
    logic                fault_set, timeout_set;
    dir_t                step_dir;
    logic                period_elapsed;
    logic                abort_req;
    logic                busy_st;
    logic [2:0]          flags;

`ifdef TEMP_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign flags   = {bus.negative, bus.positive, bus.zero};
    assign busy_st = (state != IDLE) && (state != DONE);

    // STEP + WAIT + CHECK span one STEP_DIV period, hence a lead of two cycles
    step_prescaler #(.DIV(STEP_DIV), .LEAD(2)) u_presc (
        .clk            (clk),
        .reset          (reset),
        .clr            (state == STEP),
        .period_elapsed (period_elapsed)
    );

    always_comb begin
        nstate      = state;
        fault_set   = 1'b0;
        timeout_set = 1'b0;
        step_dir    = DIR_INC;
        case (state)
            IDLE:   if (start) nstate = LOAD;
            LOAD:   nstate = SETTLE;
            SETTLE: if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) nstate = CHECK;
            CHECK: begin
                if (!flags_onehot(flags)) begin
                    fault_set = 1'b1;
                    nstate    = DONE;
                end else if (bus.zero) begin
                    nstate = DONE;
                end else if (step_count == MAX_CNT) begin
                    timeout_set = 1'b1;
                    nstate      = DONE;
                end else begin
                    nstate   = STEP;
                    step_dir = bus.positive ? DIR_DEC : DIR_INC;
                end
            end
            STEP:    nstate = WAIT;
            WAIT:    if (period_elapsed) nstate = CHECK;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (abort_req && busy_st) begin
            nstate      = IDLE;
            fault_set   = 1'b0;
            timeout_set = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            load_q     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            data_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= nstate;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
            load_q     <= (nstate == LOAD);
            inc_q      <= (nstate == STEP) && (step_dir == DIR_INC);
            dec_q      <= (nstate == STEP) && (step_dir == DIR_DEC);
            busy       <= (nstate != IDLE) && (nstate != DONE);
            done       <= (nstate == DONE);
            if (state == IDLE && start) begin
                data_q     <= init_value;
                step_count <= '0;
                fault      <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                if (nstate == STEP && step_count != MAX_CNT) step_count <= step_count + DATA_W'(1);
                if (fault_set)   fault   <= 1'b1;
                if (timeout_set) timeout <= 1'b1;
            end
        end
    end

    assign bus.load      = load_q;
    assign bus.increment = inc_q;
    assign bus.decrement = dec_q;
    assign bus.data      = data_q;
endmodule
